// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding, stall/flush sequencing and performance counters for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32,
    parameter int XZR   = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             mem_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, FLUSH = 2'b10} state_t;
    localparam logic [4:0]       ZR  = 5'(XZR);
    localparam logic [CNT_W-1:0] ONE = 1;
    state_t cur;
    logic   mem_stall, br, lu;
    assign state = cur;
    // Hazard classification in priority order; FLUSH suppresses load-use, MEM_WAIT exit evaluates as RUN
    always_comb begin
        mem_stall = dmem_req && !dmem_ack;
        br        = !mem_stall && mem_branch_taken;
        lu        = cur != FLUSH && !mem_stall && !br && ex_memread && ex_rd != ZR &&
                    (ex_rd == id_rn || ex_rd == id_rm);
    end
    // Operand forwarding, MEM result preferred over WB; reset forces regfile source
    always_comb begin
        fwd_a = !reset ? 2'b00 :
                (mem_regwrite && mem_rd == id_rn && mem_rd != ZR) ? 2'b10 :
                (wb_regwrite && wb_rd == id_rn && wb_rd != ZR) ? 2'b01 : 2'b00;
        fwd_b = !reset ? 2'b00 :
                (mem_regwrite && mem_rd == id_rm && mem_rd != ZR) ? 2'b10 :
                (wb_regwrite && wb_rd == id_rm && wb_rd != ZR) ? 2'b01 : 2'b00;
    end
    // Pipeline enables and flushes; reset holds everything enabled and flushing
    always_comb begin
        pc_en       = !reset || !(mem_stall || lu);
        ifid_en     = !reset || !(mem_stall || lu);
        idex_en     = !reset || !mem_stall;
        exmem_en    = !reset || !mem_stall;
        memwb_en    = !reset || !mem_stall;
        ifid_flush  = !reset || br;
        idex_flush  = !reset || br || lu;
        exmem_flush = !reset || br;
    end
    // State register and saturating stall/flush counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cur <= mem_stall ? MEM_WAIT : br ? FLUSH : RUN;
            if (!pc_en && stall_cnt != '1) stall_cnt <= stall_cnt + ONE;
            if (br && flush_cnt != '1) flush_cnt <= flush_cnt + ONE;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed-vector bench for pipe_hazard_ctrl (CNT_W=4 to reach saturation quickly)
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rn, id_rm, ex_rd, mem_rd, wb_rd;
    logic       ex_memread, mem_regwrite, wb_regwrite, mem_branch_taken, dmem_req, dmem_ack;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] fwd_a, fwd_b, state;
    logic [3:0] stall_cnt, flush_cnt;
    int         vectors = 0;
    int         miscompares = 0;

    pipe_hazard_ctrl #(.CNT_W(4), .XZR(31)) dut (
        .clk(clk), .reset(reset), .id_rn(id_rn), .id_rm(id_rm), .ex_rd(ex_rd),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_branch_taken(mem_branch_taken),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl);
        chk({tag, "_en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
        chk({tag, "_fl"}, {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, fl});
    endtask

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        tick();
        // reset dominates outputs even with hazards present
        dmem_req = 1'b1; mem_branch_taken = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd4; id_rn = 5'd4;
        #3;
        chk_ctl("rst_out", 5'b11111, 3'b111);
        chk("rst_fwd", {28'd0, fwd_a, fwd_b}, 32'h0);
        tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cnts", {24'd0, stall_cnt, flush_cnt}, 32'h00);
        // forwarding
        reset = 1'b1; idle();
        mem_regwrite = 1'b1; mem_rd = 5'd5; wb_regwrite = 1'b1; wb_rd = 5'd5; id_rn = 5'd5; id_rm = 5'd31;
        #3;
        chk("fwd_mem_wins_a", {30'd0, fwd_a}, 32'd2);
        chk("fwd_xzr_b", {30'd0, fwd_b}, 32'd0);
        wb_rd = 5'd31;
        #1;
        chk("fwd_wb_xzr_b", {30'd0, fwd_b}, 32'd0);
        mem_regwrite = 1'b0; wb_rd = 5'd7; id_rm = 5'd7;
        #1;
        chk("fwd_wb_a", {30'd0, fwd_a}, 32'd0);
        chk("fwd_wb_b", {30'd0, fwd_b}, 32'd1);
        mem_regwrite = 1'b1; mem_rd = 5'd31; id_rn = 5'd31;
        #1;
        chk("fwd_mem_xzr_a", {30'd0, fwd_a}, 32'd0);
        chk_ctl("normal", 5'b11111, 3'b000);
        tick();
        chk("normal_state", {30'd0, state}, 32'd0);
        // load-use
        idle(); ex_memread = 1'b1; ex_rd = 5'd3; id_rm = 5'd3;
        #3;
        chk_ctl("lu", 5'b00111, 3'b010);
        tick();
        chk("lu_state", {30'd0, state}, 32'd0);
        chk("lu_stall_cnt", {28'd0, stall_cnt}, 32'd1);
        ex_rd = 5'd31; id_rn = 5'd31;
        #3;
        chk_ctl("lu_xzr", 5'b11111, 3'b000);
        // memory wait for three cycles
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk_ctl("mw", 5'b00000, 3'b000);
            tick();
            chk("mw_state", {30'd0, state}, 32'd1);
        end
        chk("mw_stall_cnt", {28'd0, stall_cnt}, 32'd4);
        dmem_ack = 1'b1;
        #3;
        chk_ctl("mw_ack", 5'b11111, 3'b000);
        tick();
        chk("mw_exit_state", {30'd0, state}, 32'd0);
        chk("mw_exit_cnt", {28'd0, stall_cnt}, 32'd4);
        // branch flush together with load-use
        idle(); mem_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
        #3;
        chk_ctl("br", 5'b11111, 3'b111);
        tick();
        chk("br_state", {30'd0, state}, 32'd2);
        chk("br_cnts", {24'd0, stall_cnt, flush_cnt}, 32'h41);
        mem_branch_taken = 1'b0;
        #3;
        chk_ctl("flush_lu_suppressed", 5'b11111, 3'b000);
        tick();
        chk("flush_exit_state", {30'd0, state}, 32'd0);
        chk("flush_exit_stall", {28'd0, stall_cnt}, 32'd4);
        // saturation: 11 stalls reach 15, two more must hold
        idle(); dmem_req = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        chk("sat_reach", {28'd0, stall_cnt}, 32'd15);
        tick(); tick();
        chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
        chk("sat_state", {30'd0, state}, 32'd1);
        // reset during MEM_WAIT
        reset = 1'b0;
        #3;
        chk_ctl("rst_mw_out", 5'b11111, 3'b111);
        tick();
        chk("rst_mw_state", {30'd0, state}, 32'd0);
        chk("rst_mw_cnts", {24'd0, stall_cnt, flush_cnt}, 32'h00);
        // first cycle after reset behaves as RUN
        reset = 1'b1; idle(); ex_memread = 1'b1; ex_rd = 5'd9; id_rn = 5'd9;
        #3;
        chk_ctl("post_rst_lu", 5'b00111, 3'b010);
        tick();
        chk("post_rst_cnt", {28'd0, stall_cnt}, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-002 SHALL have parameter XZR, default 31, register index hardwired to zero; it never forwards and never hazards.
REQ-003 SHALL have input clk, 1 bit, the only clock; all state is updated on the rising edge.
REQ-004 SHALL have input reset, 1 bit: reset reset, synchronous, active-low; clock clk.
REQ-005 SHALL have inputs id_rn and id_rm, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have inputs ex_rd (5 bits) and ex_memread (1 bit): destination of, and load flag for, the instruction in EX.
REQ-007 SHALL have inputs mem_rd (5 bits) and mem_regwrite (1 bit): MEM-stage writeback info.
REQ-008 SHALL have inputs wb_rd (5 bits) and wb_regwrite (1 bit): WB-stage writeback info.
REQ-009 SHALL have input mem_branch_taken, 1 bit: the branch resolved in MEM is taken.
REQ-010 SHALL have inputs dmem_req and dmem_ack, 1 bit each: data-memory access pending, and access completes this cycle.
REQ-011 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en and memwb_en, 1 bit each: enables for the PC and the four pipeline registers.
REQ-012 SHALL have outputs ifid_flush, idex_flush and exmem_flush, 1 bit each: synchronous clear of the pipeline registers.
REQ-013 SHALL have outputs fwd_a and fwd_b, 2 bits each: ALU operand source, 00 = regfile, 10 = MEM result, 01 = WB result.
REQ-014 SHALL have output state, 2 bits: 00 RUN, 01 MEM_WAIT, 10 FLUSH.
REQ-015 SHALL have outputs stall_cnt and flush_cnt, CNT_W bits each: performance counters.

Function
REQ-016 fwd_a SHALL be combinational on id_rn:
- 10 when mem_regwrite=1, mem_rd==id_rn and mem_rd!=XZR;
- otherwise 01 when the same conditions hold for WB (wb_regwrite, wb_rd);
- otherwise 00.
fwd_b SHALL follow the same rule on id_rm. When both MEM and WB match, MEM SHALL win.
REQ-017 A memory stall SHALL be the condition dmem_req=1 and dmem_ack=0. It SHALL drive all five enables to 0 and all flushes to 0, in any state.
REQ-018 A branch flush SHALL occur when there is no memory stall and mem_branch_taken=1. In that cycle ifid_flush, idex_flush and exmem_flush SHALL be 1 and all enables SHALL be 1.
REQ-019 A load-use stall SHALL occur in state RUN when there is no memory stall, no branch flush, ex_memread=1, ex_rd!=XZR, and ex_rd equals id_rn or id_rm.
- In that cycle: pc_en=0, ifid_en=0, idex_flush=1; all other enables = 1.
REQ-020 Priority SHALL be memory stall > branch flush > load-use stall > normal. Normal means all enables 1 and all flushes 0.
REQ-021 FSM transitions:
- RUN -> MEM_WAIT on a memory stall.
- RUN -> FLUSH on a branch flush.
- MEM_WAIT stays in MEM_WAIT while the memory stall persists.
- MEM_WAIT, on dmem_ack=1 or dmem_req=0, SHALL evaluate that same cycle exactly as RUN (branch flush and load-use included), then go to FLUSH on a branch flush, otherwise to RUN.
- FLUSH SHALL last one cycle, with load-use detection suppressed. It SHALL go to MEM_WAIT on a memory stall, back to FLUSH on a new branch flush, otherwise to RUN.
REQ-022 stall_cnt SHALL increment by 1 in every cycle in which pc_en=0, saturating at all-ones.
REQ-023 flush_cnt SHALL increment by 1 in every branch-flush cycle, saturating at all-ones.
REQ-024 The block SHALL contain no combinational path from any output back to any input.

Reset
REQ-025 With reset=0 at a rising clk edge: state SHALL become RUN, and stall_cnt and flush_cnt SHALL become 0.
REQ-026 While reset=0, outputs SHALL be: all enables 1, all flushes 1, fwd_a=fwd_b=00, regardless of other inputs.
REQ-027 Reset asserted in MEM_WAIT or FLUSH SHALL abandon that state; the first cycle after reset rises SHALL behave as RUN.

Verification
REQ-028 Forwarding: mem_regwrite=1, mem_rd=5, wb_regwrite=1, wb_rd=5, id_rn=5, id_rm=31, wb_rd=31 alias -> fwd_a=10, fwd_b=00.
REQ-029 Load-use: RUN, ex_memread=1, ex_rd=3, id_rm=3 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1; state stays RUN.
REQ-030 Memory wait: dmem_req=1 with dmem_ack=0 for 3 cycles, then ack -> all enables 0 for 3 cycles, state=01, stall_cnt=3; ack cycle has enables 1 and next state is 00.
REQ-031 Simultaneous events: mem_branch_taken=1 together with load-use conditions -> flushes 111, pc_en=1, no stall; flush_cnt+1; next state 10, then 00.
REQ-032 Saturation and reset: preload stall_cnt to all-ones with CNT_W=4, then force a stall -> count holds at 15; then reset=0 during MEM_WAIT -> state 00 and counters 0 on the next edge.
